// File: rtl/alu_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_param
// Purpose  : Registered, parametrised ALU with valid/ready handshakes on both
//            sides. ADD/SUB/AND/OR/XOR/SLT/SLTU finish at the edge that
//            accepts them. SLL/SRL/SRA run one bit per cycle under a small
//            FSM. Result and flags are registered and are held until the
//            consumer takes them.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operands/op present
//   in_ready   out  1      block can accept an op this cycle
//   op         in   4      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,
//                          7 SLL,8 SRL,9 SRA, 10-15 reserved (result 0)
//   a          in   WIDTH  operand A (two's complement)
//   b          in   WIDTH  operand B; shifts use b[SHW-1:0] as the amount
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      consumer takes result this cycle
//   result     out  WIDTH  registered result
//   carry      out  1      registered carry flag
//   overflow   out  1      registered signed-overflow flag
//   zero       out  1      registered result == 0
//   negative   out  1      registered result[WIDTH-1]
// ============================================================================
module alu_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  // Shift-amount width; derived from WIDTH and not meant to be overridden.
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_AND  = 4'd2;
  localparam logic [3:0] c_OP_OR   = 4'd3;
  localparam logic [3:0] c_OP_XOR  = 4'd4;
  localparam logic [3:0] c_OP_SLT  = 4'd5;
  localparam logic [3:0] c_OP_SLTU = 4'd6;
  localparam logic [3:0] c_OP_SLL  = 4'd7;
  localparam logic [3:0] c_OP_SRL  = 4'd8;
  localparam logic [3:0] c_OP_SRA  = 4'd9;

  localparam logic [SHW-1:0] c_CNT_ZERO = '0;
  localparam logic [SHW-1:0] c_CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Registered outputs
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_zero;
  logic             r_negative;

  // Shift engine: working value, remaining count, latched shift op
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic [3:0]       r_shop;

  // Handshake / decode
  logic             w_accept;
  logic             w_is_shift;
  logic [SHW-1:0]   w_amt;
  logic             w_shift_start;

  // Single-cycle datapath
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  // One-bit shift step
  logic [WIDTH-1:0] w_step_val;
  logic             w_step_out;
  logic             w_last_step;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;

  assign w_is_shift    = (op == c_OP_SLL) || (op == c_OP_SRL) || (op == c_OP_SRA);
  assign w_amt         = b[SHW-1:0];
  // A zero-amount shift is handled like a one-cycle op (result = a).
  assign w_shift_start = w_is_shift && (w_amt != c_CNT_ZERO);

  // Only the step that takes the count from 1 to 0 produces the result.
  assign w_last_step = (r_state == S_SHIFT) && (r_cnt == c_CNT_ONE);

  // --------------------------------------------------------------------------
  // Single-cycle operations
  // --------------------------------------------------------------------------
  assign w_sum = {1'b0, a} + {1'b0, b};
  // a + ~b + 1: the carry out is the inverted borrow.
  assign w_dif = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op)
      c_OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res   = w_dif[WIDTH-1:0];
        w_carry = w_dif[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_AND: w_res = a & b;
      c_OP_OR:  w_res = a | b;
      c_OP_XOR: w_res = a ^ b;
      c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      // Only reached for a zero shift amount: pass a through, nothing shifted out.
      c_OP_SLL, c_OP_SRL, c_OP_SRA: w_res = a;
      default: begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // One-bit shift step on the working register
  // --------------------------------------------------------------------------
  always_comb begin
    w_step_val = r_work;
    w_step_out = 1'b0;
    case (r_shop)
      c_OP_SLL: begin
        w_step_val = {r_work[WIDTH-2:0], 1'b0};
        w_step_out = r_work[WIDTH-1];
      end
      c_OP_SRL: begin
        w_step_val = {1'b0, r_work[WIDTH-1:1]};
        w_step_out = r_work[0];
      end
      default: begin
        // SRA: replicate the sign bit.
        w_step_val = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
        w_step_out = r_work[0];
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_shift_start ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        // in_valid is ignored here; in_ready is low anyway.
        if (r_cnt <= c_CNT_ONE) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (w_accept) begin
            // Back-to-back: take the next op on the same edge.
            w_state_nxt = w_shift_start ? S_SHIFT : S_DONE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_shop     <= '0;
    end else if (w_accept) begin
      if (w_shift_start) begin
        // Result registers keep their old contents while shifting; out_valid
        // is low so nothing intermediate is ever presented.
        r_work <= a;
        r_cnt  <= w_amt;
        r_shop <= op;
      end else begin
        r_result   <= w_res;
        r_carry    <= w_carry;
        r_overflow <= w_ovf;
        r_zero     <= (w_res == '0);
        r_negative <= w_res[WIDTH-1];
      end
    end else if (r_state == S_SHIFT) begin
      r_work <= w_step_val;
      if (r_cnt != c_CNT_ZERO) begin
        r_cnt <= r_cnt - c_CNT_ONE;
      end
      if (w_last_step) begin
        r_result   <= w_step_val;
        r_carry    <= w_step_out;
        r_overflow <= 1'b0;
        r_zero     <= (w_step_val == '0);
        r_negative <= w_step_val[WIDTH-1];
      end
    end
  end

  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign zero     = r_zero;
  assign negative = r_negative;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_param
// Purpose  : Directed scoreboard bench for alu_seq_param (WIDTH=32). The
//            stimulus process pushes hand-computed expectations into a queue;
//            a monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_param;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;

  int checks;
  int failures;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic             z;
    logic             n;
    string            name;
  } exp_t;

  exp_t sb[$];

  alu_seq_param #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  // Monitor: compare on every output handshake (sampled mid-cycle).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: result=%08h with empty scoreboard", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.r || carry !== e.c || overflow !== e.v ||
            zero !== e.z || negative !== e.n) begin
          failures++;
          $display("FAIL %s: got r=%08h c=%b v=%b z=%b n=%b, need r=%08h c=%b v=%b z=%b n=%b",
                   e.name, result, carry, overflow, zero, negative,
                   e.r, e.c, e.v, e.z, e.n);
        end
      end
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] er, input logic ec, input logic ev,
                          input logic ez, input logic en, input string name);
    exp_t e;
    e.r = er; e.c = ec; e.v = ev; e.z = ez; e.n = en; e.name = name;
    sb.push_back(e);
  endtask

  task automatic check(input bit ok, input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] need);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h, need %0h", name, got, need);
    end
  endtask

  // Issue one op, then measure the edges from the accept edge until out_valid.
  task automatic issue(input logic [3:0] op_i, input logic [WIDTH-1:0] a_i,
                       input logic [WIDTH-1:0] b_i, input int lat,
                       input logic [WIDTH-1:0] er, input logic ec, input logic ev,
                       input logic ez, input logic en, input string name);
    int wait_cnt;
    int lat_cnt;
    op = op_i; a = a_i; b = b_i; in_valid = 1'b1;
    push_exp(er, ec, ev, ez, en, name);
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 100) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat_cnt = 0;
    while (!out_valid && lat_cnt < 100) begin
      @(posedge clk); #1;
      lat_cnt++;
    end
    check(out_valid && lat_cnt == lat, {name, "_latency"}, lat_cnt, lat);
  endtask

  initial begin
    int stray;
    checks = 0; failures = 0;
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
    out_ready = 1'b1;

    #12;
    check(out_valid === 1'b0 && result === '0 && carry === 1'b0 && overflow === 1'b0 &&
          zero === 1'b0 && negative === 1'b0, "reset_outputs", result, 0);
    check(in_ready === 1'b1, "reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    //    op     a             b             lat  result        c     v     z     n
    issue(4'd0, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, "add_ovf");
    issue(4'd0, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, "add_carry");
    issue(4'd1, 32'h00000005, 32'h00000005, 0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, "sub_eq");
    issue(4'd1, 32'h00000003, 32'h00000005, 0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1, "sub_borrow");
    issue(4'd1, 32'h80000000, 32'h00000001, 0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, "sub_ovf");
    issue(4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b1, "and");
    issue(4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1'b1, "or");
    issue(4'd5, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, "slt");
    issue(4'd6, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, "sltu");
    issue(4'd6, 32'h00000001, 32'hFFFFFFFF, 0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, "sltu_lt");
    issue(4'd12, 32'h12345678, 32'h9ABCDEF0, 0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, "op12");
    issue(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, "op15");
    issue(4'd9, 32'h80000001, 32'h00000004, 4, 32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b1, "sra4");
    issue(4'd7, 32'h12345678, 32'h00000000, 0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, "sll0");
    issue(4'd7, 32'hC0000000, 32'h00000001, 1, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1, "sll1");
    issue(4'd8, 32'h00000003, 32'h00000001, 1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, "srl1");
    issue(4'd7, 32'h00000001, 32'h00000021, 1, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0, "sll_amt_lowbits");
    issue(4'd9, 32'h7FFFFFFF, 32'h0000001F, 31, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, "sra31");
    issue(4'd8, 32'h80000000, 32'h0000001F, 31, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, "srl31");
    @(posedge clk); #1;

    // Backpressure: hold ADD result for 5 cycles, then back-to-back XOR.
    out_ready = 1'b0;
    op = 4'd0; a = 32'h00000001; b = 32'h00000002; in_valid = 1'b1;
    push_exp(32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0, "bp_add");
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check(out_valid === 1'b1 && in_ready === 1'b0 && result === 32'h00000003 &&
            carry === 1'b0 && overflow === 1'b0 && zero === 1'b0 && negative === 1'b0,
            "bp_hold", result, 32'h00000003);
      @(posedge clk); #1;
    end
    op = 4'd4; a = 32'hF0F0F0F0; b = 32'hFF00FF00; in_valid = 1'b1; out_ready = 1'b1;
    push_exp(32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0, "bp_xor");
    #1;
    check(in_ready === 1'b1, "bp_in_ready_release", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check(out_valid === 1'b1 && result === 32'h0FF00FF0, "bp_no_bubble", result, 32'h0FF00FF0);
    @(posedge clk); #1;
    check(out_valid === 1'b0 && in_ready === 1'b1, "bp_back_to_idle", out_valid, 0);

    // Reset in the middle of SLL by 31 when the remaining count is 10.
    op = 4'd7; a = 32'h00000001; b = 32'h0000001F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check(out_valid === 1'b0 && in_ready === 1'b0, "shift_busy", out_valid, 0);
    #2;
    rst = 1'b1;
    #1;
    check(out_valid === 1'b0 && result === '0 && carry === 1'b0 && overflow === 1'b0 &&
          zero === 1'b0 && negative === 1'b0, "midshift_reset_outputs", result, 0);
    check(in_ready === 1'b1, "midshift_reset_in_ready", in_ready, 1);
    #1;
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    check(stray == 0, "no_output_after_reset", stray, 0);
    out_ready = 1'b1;

    issue(4'd4, 32'hAAAAAAAA, 32'h55555555, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, "xor_after_reset");
    repeat (3) @(posedge clk);
    #1;
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
